// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit.
// Holds funct3 codes, FSM states, the request bundle and the fault rule.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TO_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_ACCESS,
    S_RESP
  } state_t;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [1:0]  off;
    logic [31:0] sdata;
  } lsu_req_t;

  function automatic logic lsu_fault(
    input logic       st,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic w_half;
    logic w_bad_f3;
    w_half   = (f3 == F3_H) || (f3 == F3_HU);
    w_bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    return (w_half && (off == 2'd3))
        || ((f3 == F3_W) && (off != 2'd0))
        || w_bad_f3
        || (st && f3[2]);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/data going out,
// lane extraction and extension for load data coming back.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_sdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [31:0] w_lane;

  assign o_wdata = i_sdata << {i_off, 3'b000};
  assign w_lane  = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_wstrb = 4'b1111;
    o_ldata = w_lane;
    unique case (1'b1)
      (i_funct3 == F3_B): begin
        o_wstrb = 4'b0001 << i_off;
        o_ldata = {{24{w_lane[7]}}, w_lane[7:0]};
      end
      (i_funct3 == F3_BU): begin
        o_wstrb = 4'b0001 << i_off;
        o_ldata = {24'b0, w_lane[7:0]};
      end
      (i_funct3 == F3_H): begin
        o_wstrb = 4'b0011 << i_off;
        o_ldata = {{16{w_lane[15]}}, w_lane[15:0]};
      end
      (i_funct3 == F3_HU): begin
        o_wstrb = 4'b0011 << i_off;
        o_ldata = {16'b0, w_lane[15:0]};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store stage: one data-memory transaction per request,
// with alignment checks, a ready timeout and a done/err pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] Address,
  input  logic [1:0]  Offset,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t          r_state;
  state_t          w_next;
  lsu_req_t        r_req;
  logic [TO_W-1:0] r_cnt;
  logic            r_err;
  logic [31:0]     r_ld;
  logic [3:0]      w_strb;
  logic [31:0]     w_wdata;
  logic [31:0]     w_ldata;
  logic            w_fault;
  logic            w_tmo;

  assign w_fault = lsu_fault(r_req.is_store, r_req.funct3, r_req.off);
  assign w_tmo   = (r_cnt == TO_W'(TIMEOUT - 1));

  lsu_align u_align (
    .i_funct3 (r_req.funct3),
    .i_off    (r_req.off),
    .i_sdata  (r_req.sdata),
    .i_rdata  (mem_rdata),
    .o_wstrb  (w_strb),
    .o_wdata  (w_wdata),
    .o_ldata  (w_ldata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_CHECK;
      S_CHECK:  w_next = w_fault ? S_RESP : S_ACCESS;
      S_ACCESS: if (mem_ready || w_tmo) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_ld  <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_req.is_store <= is_store;
        r_req.funct3   <= funct3;
        r_req.addr     <= Address;
        r_req.off      <= Offset;
        r_req.sdata    <= store_data;
      end
      if (r_state == S_CHECK) begin
        r_cnt <= '0;
        r_err <= w_fault;
      end
      if (r_state == S_ACCESS) begin
        if (mem_ready) begin
          r_err <= 1'b0;
          if (!r_req.is_store) r_ld <= w_ldata;
        end else if (w_tmo) begin
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign mem_req   = (r_state == S_ACCESS);
  assign mem_we    = mem_req & r_req.is_store;
  assign mem_addr  = r_req.addr;
  assign mem_wdata = w_wdata;
  // Loads never drive byte enables, even while latched.
  assign mem_wstrb = r_req.is_store ? w_strb : 4'b0000;
  assign load_data = r_ld;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_RESP);
  assign err       = done & r_err;

endmodule
